// File: rtl/scan_pkg.sv
// Shared encodings for the scanner/collector handshake and the collector FSM.
package scan_pkg;

    typedef enum logic [2:0] {
        SCAN_LOWPOWER     = 3'd0,
        SCAN_STANDBY      = 3'd1,
        SCAN_COLLECTING   = 3'd2,
        SCAN_IDLE         = 3'd3,
        SCAN_TRANSFERRING = 3'd4,
        SCAN_FLUSHING     = 3'd5
    } scan_state_t;

    typedef enum logic [1:0] {
        COLL_WAIT,
        COLL_GRANT,
        COLL_RECV,
        COLL_REFUSE
    } coll_state_t;

    localparam int DEFAULT_XFER_LEN = 4;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/scan_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO only lands
// when the head is popped on the same edge.
module scan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/scan_collector.sv
// Grants or refuses scanner transfer offers, buffers granted bursts in a FIFO
// and keeps burst statistics plus a sticky error flag.
module scan_collector
    import scan_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int XFER_LEN = DEFAULT_XFER_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        scan_state,
    input  logic              ready_to_transfer,
    input  logic              flush_req,
    input  logic              xfer_valid,
    input  logic [DATA_W-1:0] xfer_data,
    output logic              start_transfer,
    output logic              start_flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        bursts_ok,
    output logic [7:0]        bursts_dropped,
    output logic              err
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WCW = $clog2(XFER_LEN + 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]  XFER_C    = CW'(XFER_LEN);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(XFER_LEN - 1);

    coll_state_t    state;
    coll_state_t    next_state;
    logic [WCW-1:0] word_cnt;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           has_room;
    logic           offer;
    logic           burst_done;
    logic           burst_abort;
    logic           overflow;

    scan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (xfer_data),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Registered occupancy, so a pop in the decision cycle is not yet counted as free.
    assign has_room  = (DEPTH_C - fifo_count) >= XFER_C;
    assign offer     = ready_to_transfer && (scan_state == SCAN_IDLE);
    assign overflow  = push && fifo_full && !(out_ready && !fifo_empty);
    assign out_valid = !fifo_empty;
    assign busy      = (state == COLL_GRANT) || (state == COLL_RECV);

    always_comb begin
        next_state     = state;
        start_transfer = 1'b0;
        start_flush    = 1'b0;
        push           = 1'b0;
        burst_done     = 1'b0;
        burst_abort    = 1'b0;
        case (state)
            COLL_WAIT: begin
                if (offer && has_room)       next_state = COLL_GRANT;
                else if (offer || flush_req) next_state = COLL_REFUSE;
            end
            COLL_GRANT: begin
                start_transfer = 1'b1;
                next_state     = COLL_RECV;
            end
            COLL_RECV: begin
                push = xfer_valid;
                if (xfer_valid && word_cnt == LAST_WORD) begin
                    burst_done = 1'b1;
                    next_state = COLL_WAIT;
                end else if (scan_state == SCAN_LOWPOWER) begin
                    burst_abort = 1'b1;
                    next_state  = COLL_WAIT;
                end
            end
            COLL_REFUSE: begin
                start_flush = 1'b1;
                next_state  = COLL_WAIT;
            end
            default: next_state = COLL_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= COLL_WAIT;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt       <= '0;
            bursts_ok      <= '0;
            bursts_dropped <= '0;
            err            <= 1'b0;
        end else begin
            if (state == COLL_GRANT) word_cnt <= '0;
            else if (push)           word_cnt <= word_cnt + 1'b1;
            if (burst_done)            bursts_ok      <= sat_inc(bursts_ok);
            if (state == COLL_REFUSE)  bursts_dropped <= sat_inc(bursts_dropped);
            if (burst_abort || overflow) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scan_collector.sv
// Directed bench for scan_collector: FIFO output words are checked by a scoreboard
// monitor, control outputs and counters by direct comparisons after each edge.
module tb_scan_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] scan_state;
    logic       ready_to_transfer;
    logic       flush_req;
    logic       xfer_valid;
    logic [7:0] xfer_data;
    logic       start_transfer;
    logic       start_flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic [7:0] bursts_ok;
    logic [7:0] bursts_dropped;
    logic       err;

    logic       f_push;
    logic [7:0] f_data;
    logic       f_pop;
    logic [7:0] f_head;
    logic       f_full;
    logic       f_empty;
    logic [3:0] f_count;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;

    always #5 clk = ~clk;

    scan_collector dut (
        .clk               (clk),
        .reset             (reset),
        .scan_state        (scan_state),
        .ready_to_transfer (ready_to_transfer),
        .flush_req         (flush_req),
        .xfer_valid        (xfer_valid),
        .xfer_data         (xfer_data),
        .start_transfer    (start_transfer),
        .start_flush       (start_flush),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .busy              (busy),
        .bursts_ok         (bursts_ok),
        .bursts_dropped    (bursts_dropped),
        .err               (err)
    );

    scan_fifo #(.DATA_W(8), .DEPTH(8)) u_fifo_alone (
        .clk       (clk),
        .reset     (reset),
        .push      (f_push),
        .push_data (f_data),
        .pop       (f_pop),
        .head      (f_head),
        .full      (f_full),
        .empty     (f_empty),
        .count     (f_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drive one cycle of scanner inputs, then return just after the edge that consumed them.
    task automatic applyStimulus(input logic [2:0] st, input logic rtt, input logic fr,
                                 input logic xv, input logic [7:0] xd, input logic ordy);
        scan_state        = st;
        ready_to_transfer = rtt;
        flush_req         = fr;
        xfer_valid        = xv;
        xfer_data         = xd;
        out_ready         = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic doBurst(input logic [7:0] base);
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("grant_pulse", start_transfer, 1'b1);
        checkOutput("grant_no_flush", start_flush, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("recv_pulse_gone", start_transfer, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(base + 8'(i));
            applyStimulus(3'd4, 1'b0, 1'b0, 1'b1, base + 8'(i), 1'b0);
        end
        checkOutput("burst_done_busy", busy, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic fifoStep(input logic p, input logic [7:0] d, input logic q);
        f_push = p;
        f_data = d;
        f_pop  = q;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must pop the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) checkOutput("unexpected_pop", out_valid, 1'b0);
            else begin
                exp_word = exp_q.pop_front();
                checkOutput("pop_data", out_data, exp_word);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] fifo_exp [8];
        reset  = 1'b1;
        f_push = 1'b0;
        f_data = 8'h00;
        f_pop  = 1'b0;
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rst_start_transfer", start_transfer, 1'b0);
        checkOutput("rst_start_flush", start_flush, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_bursts_ok", bursts_ok, 8'd0);
        checkOutput("rst_bursts_dropped", bursts_dropped, 8'd0);
        checkOutput("rst_err", err, 1'b0);
        reset = 1'b0;

        // Single granted burst A1..A4, then read back in order.
        doBurst(8'hA1);
        checkOutput("a_bursts_ok", bursts_ok, 8'd1);
        checkOutput("a_out_valid", out_valid, 1'b1);
        checkOutput("a_head", out_data, 8'hA1);
        drain(4);
        checkOutput("a_drained", out_valid, 1'b0);
        checkOutput("a_queue_empty", exp_q.size(), 0);

        // Fill to 8, pop 3 leaving 5, then an offer must be refused.
        doBurst(8'hB1);
        doBurst(8'hB5);
        checkOutput("b_bursts_ok", bursts_ok, 8'd3);
        drain(3);
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("refuse_flush_pulse", start_flush, 1'b1);
        checkOutput("refuse_no_transfer", start_transfer, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("refuse_pulse_gone", start_flush, 1'b0);
        checkOutput("refuse_dropped", bursts_dropped, 8'd1);
        checkOutput("refuse_ok_same", bursts_ok, 8'd3);
        drain(5);
        checkOutput("b_drained", out_valid, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        checkOutput("stray_word_ignored", out_valid, 1'b0);
        checkOutput("stray_word_no_err", err, 1'b0);

        // Burst aborted by LOWPOWER after two words; partial words stay.
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_q.push_back(8'hC1);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
        exp_q.push_back(8'hC2);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("abort_err", err, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ok_same", bursts_ok, 8'd3);
        checkOutput("abort_out_valid", out_valid, 1'b1);
        drain(2);
        checkOutput("c_drained", out_valid, 1'b0);
        checkOutput("err_sticky", err, 1'b1);

        // Flush and offer together on an empty FIFO: grant wins.
        applyStimulus(3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("both_transfer", start_transfer, 1'b1);
        checkOutput("both_no_flush", start_flush, 1'b0);
        applyStimulus(3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("flush_ignored_recv", start_flush, 1'b0);
        checkOutput("recv_busy", busy, 1'b1);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            applyStimulus(3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (i == 99) checkOutput("dropped_101", bursts_dropped, 8'd101);
        end
        checkOutput("dropped_saturated", bursts_dropped, 8'd255);

        // Reset in the middle of a burst discards everything.
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b1, 8'hD1, 1'b0);
        reset = 1'b1;
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b1, 8'hD2, 1'b0);
        checkOutput("mid_rst_out_valid", out_valid, 1'b0);
        checkOutput("mid_rst_ok", bursts_ok, 8'd0);
        checkOutput("mid_rst_dropped", bursts_dropped, 8'd0);
        checkOutput("mid_rst_err", err, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        reset = 1'b0;
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_grant", start_transfer, 1'b1);
        applyStimulus(3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_abort_err", err, 1'b1);

        // Stand-alone FIFO: full push+pop, dropped push when full.
        checkOutput("f_empty_start", f_empty, 1'b1);
        for (int i = 0; i < 8; i++) fifoStep(1'b1, 8'h10 + 8'(i), 1'b0);
        checkOutput("f_full", f_full, 1'b1);
        checkOutput("f_count_8", f_count, 4'd8);
        checkOutput("f_head_oldest", f_head, 8'h10);
        fifoStep(1'b1, 8'h20, 1'b1);
        checkOutput("f_pushpop_count", f_count, 4'd8);
        checkOutput("f_pushpop_head", f_head, 8'h11);
        fifoStep(1'b1, 8'h21, 1'b0);
        checkOutput("f_overflow_count", f_count, 4'd8);
        checkOutput("f_overflow_head", f_head, 8'h11);
        fifo_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
        for (int i = 0; i < 8; i++) begin
            checkOutput("f_drain_head", f_head, fifo_exp[i]);
            fifoStep(1'b0, 8'h00, 1'b1);
        end
        checkOutput("f_empty_end", f_empty, 1'b1);

        applyStimulus(3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
